// File: rtl/prog_mem_if.sv
// Bundles the fetch port and the bus port of prog_mem.
// Handshake, identical on both ports: a request is accepted on a clock edge
// where req=1 and gnt=1. Exactly one cycle after that edge the response is
// presented with rvalid=1 for one cycle, together with rdata and err.
// gnt is combinational from req. There is no back-pressure on responses.
interface prog_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    // fetch port (read-only)
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_err;

    // bus port (read/write with byte strobes)
    logic                  bus_req;
    logic                  bus_we;
    logic [DATA_W/8-1:0]   bus_be;
    logic [ADDR_W-1:0]     bus_addr;
    logic [DATA_W-1:0]     bus_wdata;
    logic                  bus_gnt;
    logic                  bus_rvalid;
    logic [DATA_W-1:0]     bus_rdata;
    logic                  bus_err;

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata, bus_err
    );

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata, bus_err
    );
endinterface

// File: rtl/prog_mem.sv
// Synchronous program/data memory with a read-only fetch port and a
// read/write bus port with byte strobes. Both ports have a registered
// 1-cycle read. After reset an optional sequencer zero-fills the array.
module prog_mem #(
    parameter int                DATA_W       = 32,
    parameter int                DEPTH        = 4096,
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter bit                CLEAR_ON_RST = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    output logic     init_done,
    output logic     fsm_state,   // 0 = CLEAR, 1 = READY
    prog_mem_if.slave mem_if
);
    localparam int BE_W    = DATA_W / 8;
    localparam int OFF_LSB = $clog2(BE_W);
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(BE_W - 1);
    // One extra bit so a limit of 2^ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   LIMIT      = (ADDR_W + 1)'(longint'(DEPTH) * BE_W);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  clr_cnt;
    logic              init_done_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              if_rvalid_q,  bus_rvalid_q;
    logic              if_err_q,     bus_err_q;
    logic [DATA_W-1:0] if_rdata_q,   bus_rdata_q;

    logic [ADDR_W-1:0] if_off,  bus_off;
    logic              if_bad,  bus_bad;
    logic [IDX_W-1:0]  if_idx,  bus_idx;
    logic              if_fire, bus_fire;
    logic              accept;

    // Offset is taken modulo 2^ADDR_W, so addresses below BASE_ADDR wrap
    // to large offsets and land in the out-of-range error.
    function automatic logic addr_bad(input logic [ADDR_W-1:0] off);
        return ((off & ALIGN_MASK) != '0) || ({1'b0, off} >= LIMIT);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] off);
        return IDX_W'(off >> OFF_LSB);
    endfunction

    // Address decode and grant; grants are withheld during the fill and on a reset edge.
    always_comb begin
        if_off   = mem_if.if_addr  - BASE_ADDR;
        bus_off  = mem_if.bus_addr - BASE_ADDR;
        if_bad   = addr_bad(if_off);
        bus_bad  = addr_bad(bus_off);
        if_idx   = addr_idx(if_off);
        bus_idx  = addr_idx(bus_off);
        accept   = init_done_q & ~rst;
        if_fire  = mem_if.if_req  & accept;
        bus_fire = mem_if.bus_req & accept;
    end

    assign mem_if.if_gnt     = if_fire;
    assign mem_if.bus_gnt    = bus_fire;
    assign mem_if.if_rvalid  = if_rvalid_q;
    assign mem_if.if_rdata   = if_rdata_q;
    assign mem_if.if_err     = if_err_q;
    assign mem_if.bus_rvalid = bus_rvalid_q;
    assign mem_if.bus_rdata  = bus_rdata_q;
    assign mem_if.bus_err    = bus_err_q;
    assign init_done         = init_done_q;
    assign fsm_state         = (state_q == READY);

    // Fill sequencer and registered responses of both ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLEAR_ON_RST ? CLEAR : READY;
            clr_cnt      <= '0;
            init_done_q  <= 1'b0;
            if_rvalid_q  <= 1'b0;
            if_err_q     <= 1'b0;
            if_rdata_q   <= '0;
            bus_rvalid_q <= 1'b0;
            bus_err_q    <= 1'b0;
            bus_rdata_q  <= '0;
        end else begin
            case (state_q)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST_IDX) begin
                        state_q     <= READY;
                        init_done_q <= 1'b1;
                    end
                end
                READY:   init_done_q <= 1'b1;
                default: state_q     <= READY;
            endcase

            // Reading here with non-blocking semantics gives read-before-write
            // against a bus write to the same word at the same edge.
            if_rvalid_q  <= if_fire;
            if_err_q     <= if_fire & if_bad;
            if_rdata_q   <= (if_fire && !if_bad) ? mem[if_idx] : '0;
            bus_rvalid_q <= bus_fire;
            bus_err_q    <= bus_fire & bus_bad;
            bus_rdata_q  <= (bus_fire && !mem_if.bus_we && !bus_bad) ? mem[bus_idx] : '0;
        end
    end

    // Array writes: zero-fill during CLEAR, otherwise byte-strobed bus writes.
    always_ff @(posedge clk) begin
        if (!rst && state_q == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (bus_fire && mem_if.bus_we && !bus_bad) begin
            for (int k = 0; k < BE_W; k++) begin
                if (mem_if.bus_be[k]) begin
                    mem[bus_idx][k*8 +: 8] <= mem_if.bus_wdata[k*8 +: 8];
                end
            end
        end
    end
endmodule
